// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues same-cycle fetches to
// instruction memory, and feeds the registered IF/ID pair to decode.
// A stall that arrives together with a returned word parks that word in a
// one-entry hold buffer. The memory needs no request hold, so the word is
// never fetched twice and never lost.
module if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        if_redirect,
    input  logic [15:0] if_redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid
);

    typedef enum logic {FETCH, HOLD} fetchState_t;

    fetchState_t state;
    logic [15:0] pc;
    logic [15:0] holdBuf;
    logic [15:0] pcNext;

    // Modulo-2^16 increment; 16'hFFFF wraps to 16'h0000.
    assign pcNext = pc + 16'd1;

    // HOLD already has its word, so no fetch is issued there.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Priority: reset, then redirect, then stall, then normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            holdBuf     <= 16'h0000;
            if_instr    <= NOP_INSTR;
            if_pc_plus1 <= 16'h0000;
            if_valid    <= 1'b0;
        end else if (if_redirect) begin
            // Flush. Any parked word belongs to the wrong path and is dropped.
            state    <= FETCH;
            pc       <= if_redirect_pc;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready && !if_stall) begin
                        if_instr    <= imem_rdata;
                        if_pc_plus1 <= pcNext;
                        if_valid    <= 1'b1;
                        pc          <= pcNext;
                    end else if (imem_ready && if_stall) begin
                        // Park the word. IF/ID still holds the stalled
                        // instruction.
                        holdBuf <= imem_rdata;
                        state   <= HOLD;
                    end else if (!if_stall) begin
                        // Memory not ready: insert a bubble and retry the
                        // same PC.
                        if_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!if_stall) begin
                        if_instr    <= holdBuf;
                        if_pc_plus1 <= pcNext;
                        if_valid    <= 1'b1;
                        pc          <= pcNext;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
